counter_sweep_ctrl: RTL

Sequencer that drives the team's up/down loadable counter through programmed sweeps. Each sweep loads a start value, counts in a chosen direction until an end value, and repeats a programmed number of times. Controls the counter via its enable/up_down/load/set pins and watches its count output for feedback. Start/busy/done handshake toward the host logic.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_sweep_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the up/down counter and its sweep controller.
package counter_pkg;

    // Default width of the team's loadable up/down counter.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } sweep_state_e;

    // Steps needed to walk from 'from' to 'to' in the given direction, modulo 2^width.
    function automatic int unsigned mod_dist(input int unsigned from, input int unsigned to,
                                             input logic up, input int unsigned width);
        int unsigned mask;
        mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (up ? (to - from) : (from - to)) & mask;
    endfunction

endpackage

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an up/down loadable counter through repeated start->end sweeps.
// Optional feature: define SWEEP_BOUNCE_EN to add the 'bounce' input (return leg to start_val).
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned N     = CNT_W,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [N-1:0]     start_val,
    input  logic [N-1:0]     end_val,
    input  logic             dir,
    input  logic [REP_W-1:0] reps,
`ifdef SWEEP_BOUNCE_EN
    input  logic             bounce,
`endif
    input  logic             abort,
    input  logic [N-1:0]     count_in,
    output logic             cnt_en,
    output logic             cnt_up_down,
    output logic             cnt_load,
    output logic [N-1:0]     cnt_set,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] pass_cnt
);

    sweep_state_e     state_q, state_d;
    logic [N-1:0]     start_q, end_q;
    logic             dir_q;
    logic [REP_W-1:0] reps_q;
    logic             bounce_q;
    logic [REP_W-1:0] pass_q, pass_d;
    logic             leg_q, leg_d;     // 1 while on the return leg of a bounce pass
    logic             cfg_load;
    logic             bounce_in;
    logic [N-1:0]     target;
    logic             at_target;
    logic [REP_W:0]   pass_inc;
    logic [REP_W:0]   reps_eff;
    logic             last_pass;

`ifdef SWEEP_BOUNCE_EN
    assign bounce_in = bounce;
`else
    assign bounce_in = 1'b0;
`endif

    assign target    = leg_q ? start_q : end_q;
    assign at_target = (count_in == target);
    assign pass_inc  = {1'b0, pass_q} + (REP_W + 1)'(1);
    // A programmed repetition count of zero still runs one pass.
    assign reps_eff  = (reps_q == '0) ? (REP_W + 1)'(1) : {1'b0, reps_q};
    assign last_pass = (pass_inc >= reps_eff);
    assign pass_cnt  = pass_q;

    // Next-state and counter-control decode; abort gates enable/load combinationally.
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        leg_d       = leg_q;
        cfg_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_load    = 1'b0;
        cnt_set     = '0;
        cnt_up_down = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    cfg_load = 1'b1;
                    pass_d   = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                busy        = 1'b1;
                cnt_load    = !abort;
                cnt_set     = start_q;
                cnt_up_down = dir_q;
                leg_d       = 1'b0;
                state_d     = StRun;
            end
            StRun: begin
                busy        = 1'b1;
                cnt_up_down = dir_q ^ leg_q;
                cnt_en      = !at_target && !abort;
                if (at_target) begin
                    // A zero-length bounce has no return leg to walk.
                    if (bounce_q && !leg_q && (start_q != end_q)) begin
                        leg_d = 1'b1;
                    end else begin
                        pass_d  = pass_q + REP_W'(1);
                        state_d = last_pass ? StDone : StLoad;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            pass_d  = pass_q;
            leg_d   = leg_q;
        end
    end

    // State, pass counter and latched sweep configuration.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= StIdle;
            pass_q   <= '0;
            leg_q    <= 1'b0;
            start_q  <= '0;
            end_q    <= '0;
            dir_q    <= 1'b0;
            reps_q   <= '0;
            bounce_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            leg_q   <= leg_d;
            if (cfg_load) begin
                start_q  <= start_val;
                end_q    <= end_val;
                dir_q    <= dir;
                reps_q   <= reps;
                bounce_q <= bounce_in;
            end
        end
    end

endmodule
